// File: rtl/debug_serial_tx.sv
// debug_serial_tx: sends a 9-byte UART frame (sync, seven debug bytes,
// checksum) holding a snapshot of the CPU debug ports.
module debug_serial_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   baud, baud_d;
  logic [2:0]      bit_idx, bit_d;
  logic [3:0]      byte_idx, byte_d;
  logic [6:0][7:0] snap;
  logic [7:0]      csum, port_sum, cur_byte;
  logic            pending, launch, baud_last;
  logic            tx_d, busy_d, done_d;

  assign baud_last = (baud == BAUD_MAX);
  assign launch    = (state == IDLE) && (trigger || pending);
  assign port_sum  = debug_port1 + debug_port2 + debug_port3
                   + debug_port4 + debug_port5 + debug_port6
                   + debug_port7;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud       <= baud_d;
      bit_idx    <= bit_d;
      byte_idx   <= byte_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Snapshot and checksum are frozen for the whole frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap    <= '0;
      csum    <= '0;
      pending <= 1'b0;
    end else if (launch) begin
      snap    <= {debug_port7, debug_port6, debug_port5,
                  debug_port4, debug_port3, debug_port2,
                  debug_port1};
      csum    <= port_sum;
      pending <= 1'b0;
    end else if (trigger) begin
      pending <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    bit_d   = bit_idx;
    byte_d  = byte_idx;
    baud_d  = baud_last ? '0 : baud + 1'b1;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        if (launch) begin
          state_d = START;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          bit_d = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (byte_idx == 4'd8) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            byte_d  = byte_idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered
  always_comb begin
    cur_byte = SYNC_BYTE;
    unique case (byte_d)
      4'd1:    cur_byte = snap[0];
      4'd2:    cur_byte = snap[1];
      4'd3:    cur_byte = snap[2];
      4'd4:    cur_byte = snap[3];
      4'd5:    cur_byte = snap[4];
      4'd6:    cur_byte = snap[5];
      4'd7:    cur_byte = snap[6];
      4'd8:    cur_byte = csum;
      default: cur_byte = SYNC_BYTE;
    endcase
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && baud_last && (byte_idx == 4'd8);
  end

endmodule

// File: tb/tb_debug_serial_tx.sv
// tb_debug_serial_tx: directed frames decoded from the tx line and
// compared against hand-computed byte sequences.
module tb_debug_serial_tx;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            trigger = 1'b0;
  logic [6:0][7:0] dp = '0;
  logic            tx, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  debug_serial_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .debug_port1 (dp[0]),
    .debug_port2 (dp[1]),
    .debug_port3 (dp[2]),
    .debug_port4 (dp[3]),
    .debug_port5 (dp[4]),
    .debug_port6 (dp[5]),
    .debug_port7 (dp[6]),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller at the negedge inside the first start-bit cycle
  task automatic pulse_trigger();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  // Decode 9 bytes; aligned means we already sit in the first start cycle
  task automatic rx_frame(input bit aligned, input string tag,
                          output logic [8:0][7:0] f);
    int  n;
    bit  stop_ok;
    stop_ok = 1'b1;
    f = '1;
    for (int i = 0; i < 9; i++) begin
      if (!(aligned && i == 0)) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (tx !== 1'b0 && n < 2000);
      end
      check({tag, "_start"}, {71'b0, tx}, 72'd0);
      if (tx !== 1'b0) return;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        f[i][k] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx !== 1'b1) stop_ok = 1'b0;
    end
    check({tag, "_stop"}, {71'b0, stop_ok}, 72'd1);
  endtask

  logic [8:0][7:0] f1, f2;
  int              d0;
  bit              idle_ok;

  initial begin
    // Reset and idle
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {71'b0, tx}, 72'd1);
    check("rst_busy", {71'b0, busy}, 72'd0);
    check("rst_done", {71'b0, frame_done}, 72'd0);
    reset = 1'b0;
    idle_ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
        idle_ok = 1'b0;
    end
    check("idle_1000", {71'b0, idle_ok}, 72'd1);

    // Single frame 01..07
    dp = 56'h07060504030201;
    d0 = done_cnt;
    pulse_trigger();
    check("first_busy", {71'b0, busy}, 72'd1);
    rx_frame(1'b1, "f_basic", f1);
    check("f_basic", f1, 72'h1C07060504030201A5);
    @(negedge clk);
    check("done_early", {71'b0, frame_done}, 72'd0);
    @(negedge clk);
    check("done_at_360", {71'b0, frame_done}, 72'd1);
    check("done_busy", {71'b0, busy}, 72'd0);
    repeat (50) @(negedge clk);
    check("done_once", 72'(done_cnt - d0), 72'd1);

    // Checksum wrap
    dp = 56'h80800000_01FFFF;
    pulse_trigger();
    rx_frame(1'b1, "f_wrap", f1);
    check("f_wrap", f1, 72'hFF8080000001FFFFA5);
    repeat (20) @(negedge clk);

    // Snapshot isolation
    dp = 56'h70605040302010;
    pulse_trigger();
    fork
      rx_frame(1'b1, "f_snap", f1);
      begin
        repeat (95) @(negedge clk);
        dp = {7{8'h55}};
      end
    join
    check("f_snap", f1, 72'hC070605040302010A5);
    repeat (20) @(negedge clk);

    // Pending collapse: three triggers during frame 1
    dp = 56'h17161514131211;
    d0 = done_cnt;
    pulse_trigger();
    fork
      begin
        rx_frame(1'b1, "f_pend1", f1);
        @(negedge clk);
        @(negedge clk);
        check("gap_done", {71'b0, frame_done}, 72'd1);
        check("gap_tx", {71'b0, tx}, 72'd1);
        check("gap_busy", {71'b0, busy}, 72'd0);
        @(negedge clk);
        check("gap_end_busy", {71'b0, busy}, 72'd1);
        rx_frame(1'b1, "f_pend2", f2);
      end
      begin
        repeat (50) @(negedge clk);
        pulse_trigger();
        repeat (100) @(negedge clk);
        pulse_trigger();
        repeat (100) @(negedge clk);
        pulse_trigger();
        repeat (30) @(negedge clk);
        dp = 56'h27262524232221;
      end
    join
    check("f_pend1", f1, 72'h8C17161514131211A5);
    check("f_pend2", f2, 72'hFC27262524232221A5);
    repeat (400) @(negedge clk);
    check("pend_frames", 72'(done_cnt - d0), 72'd2);
    check("pend_idle", {71'b0, busy}, 72'd0);

    // Reset in the start bit of byte 4
    dp = 56'h11223344556677;
    d0 = done_cnt;
    pulse_trigger();
    repeat (161) @(negedge clk);
    check("mid_tx_low", {71'b0, tx}, 72'd0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_tx", {71'b0, tx}, 72'd1);
    check("mid_rst_busy", {71'b0, busy}, 72'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    check("mid_no_done", 72'(done_cnt - d0), 72'd0);
    check("mid_quiet", {70'b0, busy, tx}, 72'd1);
    dp = 56'h40201008040201;
    pulse_trigger();
    rx_frame(1'b1, "f_after", f1);
    check("f_after", f1, 72'h7F40201008040201A5);
    repeat (10) @(negedge clk);
    check("after_done", 72'(done_cnt - d0), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
